vec_norm: RTL and testbench

Streaming Euclidean-norm engine, the parametrised successor of the single-purpose norm block used ahead of the QR column normaliser. It accepts a variable-length vector of signed elements over a valid/ready handshake and accumulates the sum of squares at full precision. It then returns either floor(sqrt(sum)), computed by an internal bit-serial integer square root with no external CORDIC, or the raw sum of squares. The result is held under a valid/yumi handshake for the downstream Householder/Gram-Schmidt stage.

---
 rtl/vec_norm_if.sv | 28 ++
 rtl/vec_norm.sv | 147 ++++++++++++++
 tb/tb_vec_norm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/vec_norm_if.sv
// vec_norm element/result handshake bundle.
// Element side is valid/ready, result side is valid/yumi.
interface vec_norm_if #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 16
);
  localparam int ACC_W = 2*WIDTH + $clog2(MAX_LEN);

  logic [WIDTH-1:0] a_i;
  logic             v_i;
  logic             last_i;
  logic             sq_mode_i;
  logic             ready_o;
  logic [ACC_W-1:0] data_o;
  logic             len_err_o;
  logic             v_o;
  logic             yumi_i;

  modport slave (
    input  a_i, v_i, last_i, sq_mode_i, yumi_i,
    output ready_o, data_o, len_err_o, v_o
  );

  modport master (
    output a_i, v_i, last_i, sq_mode_i, yumi_i,
    input  ready_o, data_o, len_err_o, v_o
  );
endinterface

// File: rtl/vec_norm.sv
// Streaming sum-of-squares with bit-serial floor(sqrt).
// One element per cycle in, one result held until yumi.
module vec_norm #(
  parameter int WIDTH   = 16,
  parameter int MAX_LEN = 16
) (
  input  logic      clk_i,
  input  logic      reset_ni,
  vec_norm_if.slave bus
);
  localparam int ACC_W  = 2*WIDTH + $clog2(MAX_LEN);
  localparam int ROOT_W = (ACC_W + 1) / 2;
  localparam int OP_W   = 2*ROOT_W;
  localparam int CNT_W  = $clog2(MAX_LEN);
  localparam int IT_W   = $clog2(ROOT_W);
  localparam int SH_W   = ROOT_W + 4;

  typedef enum logic [1:0] {eACC, eROOT, eDONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                mode_q, mode_d;
  logic                err_q, err_d;
  logic [ACC_W-1:0]    data_q, data_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ROOT_W+1:0]   rem_q, rem_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [IT_W-1:0]     it_q, it_d;

  logic signed [WIDTH-1:0]   a_s;
  logic signed [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0]        sq;
  logic [ACC_W-1:0]          acc_nxt;
  logic                      mode_eff;
  logic                      vec_end;
  logic [SH_W-1:0]           rem_sh;
  logic [SH_W-1:0]           trial;
  logic [SH_W:0]             diff;
  logic                      ge;
  logic [ROOT_W-1:0]         root_nx;

  assign a_s     = bus.a_i;
  assign prod    = a_s * a_s;
  assign sq      = prod;
  assign acc_nxt = ((cnt_q == '0) ? '0 : acc_q)
                 + ACC_W'(sq);
  assign mode_eff = (cnt_q == '0) ? bus.sq_mode_i
                                  : mode_q;
  assign vec_end = bus.last_i
                || (cnt_q == CNT_W'(MAX_LEN-1));

  // Remainder stays below 2^(ROOT_W+2); any upper
  // bit set in diff means the trial did not fit.
  assign rem_sh  = {rem_q, op_q[OP_W-1 -: 2]};
  assign trial   = {2'b00, root_q, 2'b01};
  assign diff    = {1'b0, rem_sh} - {1'b0, trial};
  assign ge      = ~|diff[SH_W:ROOT_W+2];
  assign root_nx = {root_q[ROOT_W-2:0], ge};

  assign bus.ready_o   = (state_q == eACC);
  assign bus.v_o       = (state_q == eDONE);
  assign bus.data_o    = data_q;
  assign bus.len_err_o = err_q;

  // Next-state: accumulate, root iterations, hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    err_d   = err_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    root_d  = root_q;
    it_d    = it_q;
    unique case (state_q)
      eACC: begin
        if (bus.v_i) begin
          acc_d = acc_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == '0) mode_d = bus.sq_mode_i;
          if (vec_end) begin
            cnt_d = '0;
            err_d = ~bus.last_i;
            if (mode_eff) begin
              state_d = eDONE;
              data_d  = acc_nxt;
            end else begin
              state_d = eROOT;
              op_d    = OP_W'(acc_nxt);
              rem_d   = '0;
              root_d  = '0;
              it_d    = '0;
            end
          end
        end
      end
      eROOT: begin
        op_d   = op_q << 2;
        rem_d  = ge ? diff[ROOT_W+1:0]
                    : rem_sh[ROOT_W+1:0];
        root_d = root_nx;
        it_d   = it_q + IT_W'(1);
        if (it_q == IT_W'(ROOT_W-1)) begin
          state_d = eDONE;
          data_d  = ACC_W'(root_nx);
        end
      end
      eDONE: begin
        if (bus.yumi_i) begin
          state_d = eACC;
          err_d   = 1'b0;
        end
      end
      default: state_d = eACC;
    endcase
  end

  // State and datapath registers, cleared on reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= eACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      it_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      it_q    <= it_d;
    end
  end
endmodule

// File: tb/tb_vec_norm.sv
// Directed bench for vec_norm.
// Expected results queue up as vectors are driven.
module tb_vec_norm;
  localparam int WIDTH   = 16;
  localparam int MAX_LEN = 16;
  localparam int ROOT_W  = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vec_norm_if #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) bus();

  vec_norm #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk_i    (clk),
    .reset_ni (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    bit     err;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   elem[32];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic longint isqrt(input longint s);
    longint r, t;
    r = 0;
    for (int b = 24; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= s) r = t;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input bit mode,
                         input bit no_last,
                         input int lat, input int bp);
    longint s;
    exp_t   e;
    int     k;
    s = 0;
    for (int i = 0; i < n; i++)
      s += longint'(elem[i]) * longint'(elem[i]);
    e.data = mode ? s : isqrt(s);
    e.err  = no_last && (n == MAX_LEN);
    sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      bus.a_i       = WIDTH'(elem[i]);
      bus.v_i       = 1'b1;
      bus.last_i    = !no_last && (i == n-1);
      bus.sq_mode_i = mode;
      chk("ready_acc", 64'(bus.ready_o), 64'd1);
      tick();
    end
    bus.v_i    = 1'b0;
    bus.last_i = 1'b0;
    k = 0;
    while (bus.v_o !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("latency", 64'(k), 64'(lat));
    e = sb.pop_front();
    chk("data", 64'(bus.data_o), 64'(e.data));
    chk("len_err", 64'(bus.len_err_o), 64'(e.err));
    for (int j = 0; j < bp; j++) begin
      bus.a_i    = WIDTH'(7);
      bus.v_i    = j[0];
      bus.last_i = 1'b1;
      tick();
      chk("bp_data", 64'(bus.data_o), 64'(e.data));
      chk("bp_ready", 64'(bus.ready_o), 64'd0);
      chk("bp_v", 64'(bus.v_o), 64'd1);
    end
    bus.v_i       = 1'b0;
    bus.last_i    = 1'b0;
    bus.yumi_i    = 1'b1;
    tick();
    bus.yumi_i = 1'b0;
    chk("v_after_yumi", 64'(bus.v_o), 64'd0);
    chk("ready_after_yumi", 64'(bus.ready_o), 64'd1);
  endtask

  initial begin
    int n;
    bit m;
    bus.a_i       = '0;
    bus.v_i       = 1'b0;
    bus.last_i    = 1'b0;
    bus.sq_mode_i = 1'b0;
    bus.yumi_i    = 1'b0;
    repeat (3) tick();
    chk("rst_data", 64'(bus.data_o), 64'd0);
    chk("rst_v", 64'(bus.v_o), 64'd0);
    chk("rst_err", 64'(bus.len_err_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.ready_o), 64'd1);

    elem[0] = 3; elem[1] = 4;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);
    elem[0] = -3; elem[1] = -4;
    run_vec(2, 1'b1, 1'b0, 0, 0);
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);
    elem[0] = 1; elem[1] = 1;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);
    elem[0] = 0;
    run_vec(1, 1'b0, 1'b0, ROOT_W, 0);
    elem[0] = 2; elem[1] = 3;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);

    for (int i = 0; i < MAX_LEN; i++) elem[i] = -32768;
    run_vec(MAX_LEN, 1'b0, 1'b0, ROOT_W, 0);
    run_vec(MAX_LEN, 1'b1, 1'b0, 0, 0);
    run_vec(MAX_LEN, 1'b0, 1'b1, ROOT_W, 0);
    elem[0] = 5;
    run_vec(1, 1'b0, 1'b0, ROOT_W, 0);

    elem[0] = 7; elem[1] = 24;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 7);
    elem[0] = 5; elem[1] = 12;
    run_vec(2, 1'b1, 1'b0, 0, 0);
    elem[0] = -8; elem[1] = 15;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);

    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 6));
      m = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++)
        elem[i] = int'($urandom_range(0, 65535)) - 32768;
      run_vec(n, m, 1'b0, m ? 0 : ROOT_W, 0);
    end

    bus.a_i       = WIDTH'(3);
    bus.v_i       = 1'b1;
    bus.sq_mode_i = 1'b0;
    tick();
    bus.a_i    = WIDTH'(4);
    bus.last_i = 1'b1;
    tick();
    bus.v_i    = 1'b0;
    bus.last_i = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rstroot_data", 64'(bus.data_o), 64'd0);
    chk("rstroot_v", 64'(bus.v_o), 64'd0);
    chk("rstroot_err", 64'(bus.len_err_o), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    elem[0] = 6;
    run_vec(1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.a_i       = WIDTH'(9);
      bus.v_i       = 1'b1;
      bus.sq_mode_i = 1'b0;
      tick();
    end
    bus.a_i = WIDTH'(9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstvec_data", 64'(bus.data_o), 64'd0);
    chk("rstvec_v", 64'(bus.v_o), 64'd0);
    chk("rstvec_err", 64'(bus.len_err_o), 64'd0);
    bus.v_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    elem[0] = 6; elem[1] = 8;
    run_vec(2, 1'b0, 1'b0, ROOT_W, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
